// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: control codes, the
// legality check for those codes, and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // 0110 and 1000-1111 have no ALU operation behind them.
  function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
    logic legal;
    case (ctrl)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SLL, ALU_SRL: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and on
// contention the pointer picks the winner. Purely combinational.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o,
  output logic [1:0] gnt_onehot_o
);

  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_idx_o   = 1'b0;
    case (valid_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ptr_i;
      default: gnt_idx_o = 1'b0;
    endcase
    gnt_onehot_o = gnt_valid_o ? (2'b01 << gnt_idx_o) : 2'b00;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one external combinational ALU between two requesters:
// accept (IDLE) -> drive ALU from issue regs (ISSUE) -> hold response (RESP).
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][CTRL_W-1:0] req_ctrl,
  input  logic [1:0][DATA_W-1:0] req_op1,
  input  logic [1:0][DATA_W-1:0] req_op2,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_err,
  output logic [CTRL_W-1:0]      alu_ctrl,
  output logic [DATA_W-1:0]      alu_op1,
  output logic [DATA_W-1:0]      alu_op2,
  input  logic [DATA_W-1:0]      alu_result
);

  arb_state_t        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_q, grant_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [DATA_W-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic              arb_valid;
  logic              arb_idx;
  logic [1:0]        arb_onehot;
  logic [1:0]        req_ready_c;
  logic              ctrl_legal;

  rr_arbiter2 u_rr_arbiter2 (
    .valid_i      (req_valid),
    .ptr_i        (rr_ptr_q),
    .gnt_valid_o  (arb_valid),
    .gnt_idx_o    (arb_idx),
    .gnt_onehot_o (arb_onehot)
  );

  // Codes wider than 4 bits are only legal when the extra bits are zero.
  assign ctrl_legal = alu_ctrl_legal(ctrl_q[3:0]) && ((ctrl_q >> 4) == '0);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    ctrl_d      = ctrl_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    result_d    = result_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = 2'b00;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          req_ready_c = arb_onehot;
          grant_d     = arb_idx;
          ctrl_d      = req_ctrl[arb_idx];
          op1_d       = req_op1[arb_idx];
          op2_d       = req_op2[arb_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Undefined codes still forward whatever the ALU returns.
        result_d    = alu_result;
        err_d       = ~ctrl_legal;
        rsp_valid_d = 2'b01 << grant_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          rr_ptr_d    = ~grant_q;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      ctrl_q      <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      ctrl_q      <= ctrl_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      result_q    <= result_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Nothing may look accepted while the block is held in reset.
  assign req_ready  = req_ready_c & {2{rst_n}};
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign alu_ctrl   = ctrl_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural ALU attached;
// expected responses are queued at acceptance and popped by the monitor.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } req_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][CW-1:0] req_ctrl;
  logic [1:0][DW-1:0] req_op1, req_op2;
  logic [DW-1:0]      rsp_result, alu_op1, alu_op2, alu_result;
  logic               rsp_err;
  logic [CW-1:0]      alu_ctrl;

  int   checks = 0;
  int   errors = 0;
  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];
  logic m_busy = 1'b0;
  logic m_ptr  = 1'b0;
  int   m_age  = 0;

  function automatic logic [DW-1:0] alu_f(input logic [CW-1:0] c,
                                          input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic undef_code(input logic [CW-1:0] c);
    return (c == 4'd6) || (c >= 4'd8);
  endfunction

  function automatic req_t mk(input logic [CW-1:0] c, input logic [DW-1:0] a,
                              input logic [DW-1:0] b);
    req_t r;
    r.c = c;
    r.a = a;
    r.b = b;
    return r;
  endfunction

  assign alu_result = alu_f(alu_ctrl, alu_op1, alu_op2);

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_ctrl   (alu_ctrl),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic die(input string nm);
    $display("FAIL %s bound expired t=%0t", nm, $time);
    $fatal(1, "stopping: %s", nm);
  endtask

  // Monitor / scoreboard: the only process that compares or counts.
  initial begin : monitor
    logic       in_reset;
    logic       busy_before;
    logic [1:0] exp_rdy;
    logic       p;
    exp_t       e;
    in_reset = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        if (!in_reset) begin
          #1;
          chk("reset_req_ready", 32'(req_ready), 32'(0));
          chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
          chk("reset_rsp_result", rsp_result, 32'(0));
          chk("reset_rsp_err", 32'(rsp_err), 32'(0));
          chk("reset_alu_ctrl", 32'(alu_ctrl), 32'(0));
          chk("reset_alu_op1", alu_op1, 32'(0));
          chk("reset_alu_op2", alu_op2, 32'(0));
        end
        in_reset = 1'b1;
        exp_q.delete();
        m_busy = 1'b0;
        m_age  = 0;
        m_ptr  = 1'b0;
      end else begin
        in_reset = 1'b0;
        chk("rsp_valid_onehot0", 32'($countones(rsp_valid) <= 1), 32'(1));
        chk("req_ready_onehot0", 32'($countones(req_ready) <= 1), 32'(1));
        busy_before = m_busy;
        if (m_busy) begin
          e = exp_q[0];
          m_age++;
          if (m_age < 2) begin
            chk("rsp_valid_early", 32'(rsp_valid), 32'(0));
          end else begin
            chk("rsp_valid_port", 32'(rsp_valid), 32'(2'b01 << e.port));
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            if (rsp_ready[e.port]) begin
              $display("rsp port=%0d result=0x%08h err=%0d t=%0t",
                       e.port, rsp_result, rsp_err, $time);
              void'(exp_q.pop_front());
              m_busy = 1'b0;
              m_ptr  = ~e.port;
            end
          end
        end else begin
          chk("rsp_valid_idle", 32'(rsp_valid), 32'(0));
        end
        if (busy_before) begin
          chk("req_ready_busy", 32'(req_ready), 32'(0));
        end else begin
          case (req_valid)
            2'b01:   exp_rdy = 2'b01;
            2'b10:   exp_rdy = 2'b10;
            2'b11:   exp_rdy = m_ptr ? 2'b10 : 2'b01;
            default: exp_rdy = 2'b00;
          endcase
          chk("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
          if (exp_rdy != 2'b00) begin
            p       = exp_rdy[1];
            e.port  = p;
            e.res   = alu_f(req_ctrl[p], req_op1[p], req_op2[p]);
            e.err   = undef_code(req_ctrl[p]);
            exp_q.push_back(e);
            m_busy  = 1'b1;
            m_age   = 0;
          end
        end
      end
    end
  end

  // mode 0: rsp_ready=11; 1: random; 2: 00 for the first `hold` cycles.
  task automatic run(input int mode, input int hold, input int p1_delay,
                     input bit dense, input int budget);
    logic [1:0] acc;
    req_t       r;
    int         cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < 2; p++)
        if (req_valid[p] && acc[p]) req_valid[p] = 1'b0;
      if (!req_valid[0] && q0.size() > 0 && (dense || $urandom_range(0, 2) == 0)) begin
        r = q0.pop_front();
        req_ctrl[0] = r.c; req_op1[0] = r.a; req_op2[0] = r.b; req_valid[0] = 1'b1;
      end
      if (!req_valid[1] && q1.size() > 0 && cyc >= p1_delay &&
          (dense || $urandom_range(0, 2) == 0)) begin
        r = q1.pop_front();
        req_ctrl[1] = r.c; req_op1[1] = r.a; req_op2[1] = r.b; req_valid[1] = 1'b1;
      end
      case (mode)
        0:       rsp_ready = 2'b11;
        1:       rsp_ready = 2'($urandom);
        default: rsp_ready = (cyc < hold) ? 2'b00 : 2'b11;
      endcase
      if (q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00 && !m_busy) break;
      if (cyc > budget) die("drain");
    end
  endtask

  initial begin : stim
    logic ok;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_ctrl = '0;
    req_op1 = '0;
    req_op2 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    q0.push_back(mk(4'd0, 32'd5, 32'd7));          // ADD -> 12
    run(0, 0, 0, 1'b1, 50);
    q0.push_back(mk(4'd5, 32'd1, 32'd33));         // SLL by 33 -> 2
    run(0, 0, 0, 1'b1, 50);
    q1.push_back(mk(4'd1, 32'd3, 32'd5));          // SUB -> FFFFFFFE
    run(0, 0, 0, 1'b1, 50);

    for (int i = 0; i < 4; i++) begin              // continuous contention
      q0.push_back(mk(4'd0, 32'd1, 32'd1));
      q1.push_back(mk(4'd4, 32'hF, 32'h3));
    end
    run(0, 0, 0, 1'b1, 200);

    q0.push_back(mk(4'd2, 32'hFF, 32'h0F));         // backpressure on port 0
    q1.push_back(mk(4'd0, 32'd10, 32'd20));
    run(2, 8, 2, 1'b1, 200);

    q0.push_back(mk(4'd6, 32'd9, 32'd9));           // undefined code
    run(0, 0, 0, 1'b1, 50);

    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(4'($urandom_range(0, 15)), $urandom, $urandom));
      q1.push_back(mk(4'($urandom_range(0, 15)), $urandom, 32'($urandom_range(0, 63))));
    end
    run(1, 0, 0, 1'b0, 8000);

    q0.push_back(mk(4'd0, 32'd2, 32'd3));           // leaves pointer at port 1
    run(0, 0, 0, 1'b1, 50);

    @(posedge clk);
    #1;
    req_ctrl[1] = 4'd0; req_op1[1] = 32'd100; req_op2[1] = 32'd23;
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[1];
    end
    if (!ok) die("reset_test_accept");
    @(posedge clk);
    #1 req_valid = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid[1];
    end
    if (!ok) die("reset_test_resp");
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;

    q0.push_back(mk(4'd3, 32'hF0, 32'h0F));          // contention right after reset
    q1.push_back(mk(4'd7, 32'h80, 32'd4));
    run(0, 0, 0, 1'b1, 50);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
